// File: rtl/shr_link_sched.sv
// rtl/shr_link_sched.sv - round-robin scheduler sharing one serial shift-register link
// between two frame requesters (shift MSB first, sync strobe, idle gap).
module shr_link_sched #(
  parameter int DATA_W = 16,
  parameter int DIV    = 4,
  parameter int SYN_W  = 2,
  parameter int GAP    = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              shr_clk,
  output logic              shr_din,
  output logic              shr_syn,
  output logic              clk_out_en,
  output logic              out_en
);

  localparam int SYNC_LEN = SYN_W * 2 * DIV;
  localparam int CNT_TOP  = (SYNC_LEN > GAP) ? SYNC_LEN : GAP;
  localparam int CNT_W    = $clog2(CNT_TOP + 1);
  localparam int BIT_W    = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_PRE  = CNT_W'(SYNC_LEN - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_SYNC  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  // Holds the bits still to be sent; the current bit lives in din_q.
  logic [DATA_W-2:0] sreg_q, sreg_d;
  logic              ptr_q, ptr_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clk_q, clk_d;
  logic              din_q, din_d;
  logic              syn_q, syn_d;
  logic              clk_en_q, clk_en_d;
  logic              out_en_q, out_en_d;

  logic              win0, win1;
  logic [DATA_W-1:0] sel_data;

  // ptr_q=0 favours req0 on a tie, ptr_q=1 favours req1.
  always_comb begin
    win0     = req0 & (~req1 | ~ptr_q);
    win1     = req1 & (~req0 | ptr_q);
    sel_data = win0 ? data0 : data1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    ptr_d    = ptr_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    clk_d    = clk_q;
    din_d    = din_q;
    syn_d    = syn_q;
    clk_en_d = clk_en_q;
    out_en_d = out_en_q;

    case (state_q)
      ST_IDLE: begin
        if (win0 || win1) begin
          state_d  = ST_SHIFT;
          gnt0_d   = win0;
          gnt1_d   = win1;
          ptr_d    = win0;
          sreg_d   = sel_data[DATA_W-2:0];
          din_d    = sel_data[DATA_W-1];
          busy_d   = 1'b1;
          clk_d    = 1'b0;
          cnt_d    = '0;
          bit_d    = '0;
          clk_en_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
          if (!clk_q) begin
            clk_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            state_d  = ST_SYNC;
            clk_d    = 1'b0;
            din_d    = 1'b0;
            syn_d    = 1'b1;
            clk_en_d = 1'b0;
            out_en_d = 1'b1;
          end else begin
            clk_d  = 1'b0;
            bit_d  = bit_q + BIT_ONE;
            din_d  = sreg_q[DATA_W-2];
            sreg_d = sreg_q << 1;
          end
        end
      end

      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d  = ST_GAP;
          cnt_d    = '0;
          syn_d    = 1'b0;
          out_en_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          done_d = (cnt_q == SYNC_PRE);
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset clears the link outputs at once so a partial frame is never latched.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sreg_q   <= '0;
      ptr_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_q    <= 1'b0;
      din_q    <= 1'b0;
      syn_q    <= 1'b0;
      clk_en_q <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sreg_q   <= sreg_d;
      ptr_q    <= ptr_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clk_q    <= clk_d;
      din_q    <= din_d;
      syn_q    <= syn_d;
      clk_en_q <= clk_en_d;
      out_en_q <= out_en_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign shr_clk    = clk_q;
  assign shr_din    = din_q;
  assign shr_syn    = syn_q;
  assign clk_out_en = clk_en_q;
  assign out_en     = out_en_q;

endmodule
